// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, fetch FSM
// encoding, FIFO entry layout and the decode-side no-op word.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // Decode treats an all-zero word as an R-format no-op.
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_ISSUE = 1'b0,
    FETCH_WAIT  = 1'b1
  } fetch_state_e;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, the
// valid/ready hand-off to decode and the redirect from execute.
// master = fetch unit, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// instr_fifo: parameterised synchronous FIFO with flush. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
// Push while full is accepted only when a pop happens in the same cycle.
module instr_fifo #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush empties the buffer regardless of push/pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are meaningful, and consumers mask the head when empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues single-outstanding word reads to
// instruction memory, buffers returned words in instr_fifo and hands them to
// decode over valid/ready. Redirects flush the buffer and retarget the PC;
// a response to a request made before a redirect is discarded.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/redirect
// counter outputs.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] PC_STEP    = 32'd4
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_redirect_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              drop_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  logic [CNT_W:0]    occupancy;
  logic              slot_free;
  logic              issue;
  logic [ADDR_W-1:0] target_pc;

  assign target_pc = align_word(bus.redirect_pc);

  // Occupancy counts the slot held back for an outstanding request, so a
  // response always has room when it returns.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state_q == FETCH_WAIT)};
  assign slot_free = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  assign issue     = !reset && (state_q == FETCH_ISSUE) && slot_free && !bus.redirect;
  assign fifo_push = (state_q == FETCH_WAIT) && bus.imem_valid && !drop_q && !bus.redirect;
  assign fifo_pop  = bus.instr_valid && bus.instr_ready;

  assign push_entry = '{instr: bus.imem_rdata, pc: fetch_pc_q};

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? NOP_WORD : head_entry.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head_entry.pc;

  // Fetch FSM: PC, request/response tracking and stale-response drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_ISSUE;
      fetch_pc_q <= align_word(RESET_PC);
      drop_q     <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc_q <= target_pc;
      if (state_q == FETCH_WAIT) begin
        if (bus.imem_valid) begin
          // The in-flight response lands now and is thrown away here.
          state_q <= FETCH_ISSUE;
          drop_q  <= 1'b0;
        end else begin
          drop_q  <= 1'b1;
        end
      end
    end else begin
      case (state_q)
        FETCH_ISSUE: begin
          if (issue) state_q <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (bus.imem_valid) begin
            state_q <= FETCH_ISSUE;
            drop_q  <= 1'b0;
            // A dropped response means fetch_pc already holds the target.
            if (!drop_q) fetch_pc_q <= fetch_pc_q + PC_STEP;
          end
        end
      endcase
    end
  end

  instr_fifo #(
    .DATA_W ($bits(fetch_entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (bus.redirect),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The slot reservation guarantees a response never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Saturating event counters: decode starved, and redirects taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (!bus.instr_valid && bus.instr_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.redirect && (redirect_cnt_q != '1))
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A behavioural memory with
// configurable latency answers requests; accepted responses are pushed to a
// scoreboard queue and compared against words popped by the decode side.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2),
    .PC_STEP    (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // memory model
  int          lat;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          pend_stale;
  bit          resp_now;
  logic [31:0] resp_addr;
  bit          resp_stale;

  // reference model / bookkeeping
  fetch_entry_t exp_q[$];
  logic [31:0]  next_addr;
  logic [31:0]  pop_log[$];
  logic [31:0]  req_log[$];
  int           n_pop;
  int           n_req;
  int           stall_model;
  logic         s_req;
  logic [31:0]  s_addr;
  logic         s_valid;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  // One clock cycle: sample at negedge, update model, then advance memory.
  task automatic cycle();
    fetch_entry_t e;
    @(negedge clk);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.instr_valid;
    if (!reset) begin
      if (!s_valid && bus.instr_ready) stall_model++;
      if (s_valid && bus.instr_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("instr_pc", bus.instr_pc, e.pc);
          check("instr", bus.instr, e.instr);
        end
        n_pop++;
        pop_log.push_back(bus.instr_pc);
      end
      if (resp_now && !resp_stale && !bus.redirect) begin
        e.instr = mem_word(resp_addr);
        e.pc    = resp_addr;
        exp_q.push_back(e);
        next_addr = resp_addr + 32'd4;
      end
      if (s_req) begin
        check("req_addr", s_addr, next_addr);
        check("one_outstanding", pend | resp_now, 0);
        if (bus.redirect) check("req_suppressed", s_req & bus.redirect, 0);
        pend       = 1'b1;
        pend_cnt   = lat;
        pend_addr  = s_addr;
        pend_stale = bus.redirect;
        n_req++;
        req_log.push_back(s_addr);
      end
      if (bus.redirect) begin
        exp_q.delete();
        next_addr = bus.redirect_pc & ~32'h3;
        if (pend) pend_stale = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    resp_now        = 1'b0;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        resp_now       = 1'b1;
        resp_addr      = pend_addr;
        resp_stale     = pend_stale;
        pend           = 1'b0;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = mem_word(pend_addr);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    exp_q.delete();
    pend           = 1'b0;
    resp_now       = 1'b0;
    bus.imem_valid = 1'b0;
    next_addr      = RESET_PC;
    stall_model    = 0;
    check("rst_req",   bus.imem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_pc",    bus.instr_pc, 0);
    reset = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    cycle();
    bus.redirect    = 1'b0;
  endtask

  initial begin
    bit found;
    reset           = 1'b1;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    lat = 1; pend = 0; resp_now = 0; n_pop = 0; n_req = 0; stall_model = 0;
    next_addr = RESET_PC;

    // T1: free-running 1-cycle memory, decode always ready
    do_reset(3);
    n_pop = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i == 0) check("t1_req_c0", s_req, 1);
      check($sformatf("t1_valid_c%0d", i), s_valid, (i == 2));
    end
    repeat (20) cycle();
    check("t1_pops", n_pop, 11);

    // T2: decode stalled, buffer fills to depth then requests stop
    bus.instr_ready = 1'b0;
    do_reset(2);
    n_req = 0;
    repeat (10) cycle();
    check("t2_reqs", n_req, 2);
    check("t2_req_held", s_req, 0);
    check("t2_buffered", s_valid, 1);
    bus.instr_ready = 1'b1;
    pop_log.delete();
    repeat (4) cycle();
    check("t2_npop", pop_log.size() >= 2, 1);
    if (pop_log.size() >= 2) begin
      check("t2_pop0", pop_log[0], 32'h0);
      check("t2_pop1", pop_log[1], 32'h4);
    end

    // T3: redirect while waiting on a 3-cycle memory
    lat = 3;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (s_req && s_addr == 32'h8) found = 1;
    end
    check("t3_reached_pc8", found, 1);
    pulse_redirect(32'h0000_0103);
    req_log.delete();
    pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() == 0; i++) cycle();
    check("t3_popped", pop_log.size() != 0, 1);
    if (req_log.size() != 0) check("t3_next_req", req_log[0], 32'h100);
    else check("t3_next_req_seen", req_log.size(), 1);
    if (pop_log.size() != 0) check("t3_first_pc", pop_log[0], 32'h100);

    // T4: redirect coincident with the memory response
    lat = 2;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (resp_now && resp_addr == 32'h4) found = 1;
    end
    check("t4_reached_resp", found, 1);
    pulse_redirect(32'h0000_0200);
    cycle();
    check("t4_req", s_req, 1);
    check("t4_addr", s_addr, 32'h200);
    check("t4_empty", s_valid, 0);
    pop_log.delete();
    repeat (10) cycle();
    check("t4_popped", pop_log.size() != 0, 1);
    if (pop_log.size() != 0) check("t4_first_pc", pop_log[0], 32'h200);

    // T5: reset during WAIT, stale response in the first cycle after reset
    lat = 3;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_req) found = 1;
    end
    check("t5_in_wait", found, 1);
    do_reset(2);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        check("t5_req", s_req, 1);
        check("t5_addr", s_addr, RESET_PC);
      end
      check($sformatf("t5_valid_c%0d", i), s_valid, (i == 4));
    end

    // T6: PC wrap at the top of the address space, then more redirects
    lat = 1;
    do_reset(2);
    pulse_redirect(32'hFFFF_FFFC);
    req_log.delete();
    repeat (6) cycle();
    check("t6_nreq", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      check("t6_req_top", req_log[0], 32'hFFFF_FFFC);
      check("t6_req_wrap", req_log[1], 32'h0);
    end
    pulse_redirect(32'h0000_0040); cycle(); cycle();
    pulse_redirect(32'h0000_0080); cycle(); cycle();
    pulse_redirect(32'h0000_00C0); cycle(); cycle();
    pulse_redirect(32'h0000_0107);
    req_log.delete();
    repeat (4) cycle();
    if (req_log.size() != 0) check("t6_last_target", req_log[0], 32'h104);
    else check("t6_last_target_seen", req_log.size(), 1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_redirect", perf_redirect_cnt, 5);
    check("perf_stall", perf_stall_cnt, stall_model);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end producer of the 32-bit instruction word consumed by the MIPS decode/control stage.
- Owns the PC. Issues single-outstanding word reads to instruction memory and buffers returned words in a small FIFO.
- Hands words to decode over a valid/ready handshake.
- Redirects on the Branch/Jump resolution coming back from decode/execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  request strobe; one cycle per request.
- imem_addr  out  32  byte address of the request; bits[1:0] always 0.
- imem_valid  in  1  response strobe, ≥1 cycle after imem_req.
- imem_rdata  in  32  instruction word; sampled when imem_valid=1.
- instr  out  32  instruction word to decode.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  decode accepts; a transfer occurs when instr_valid && instr_ready.
- redirect  in  1  Branch-taken or Jump resolved this cycle.
- redirect_pc  in  32  target; bits[1:0] ignored and forced to 0.

Behaviour:
- Reset (sync, active-high): fetch_pc=RESET_PC; FIFO empty; FSM=ISSUE; drop flag=0; imem_req=0; instr_valid=0; instr=0; instr_pc=0.
- FSM states:
  - ISSUE: imem_req=1 and imem_addr=fetch_pc when the FIFO has at least one free slot, counting the slot reserved for the outstanding request. Otherwise hold with imem_req=0. An issued request moves the FSM to WAIT.
  - WAIT: no new request. On imem_valid:
    - drop=0: push {imem_rdata, fetch_pc}, fetch_pc += PC_STEP, go to ISSUE.
    - drop=1: discard the word, clear drop, go to ISSUE; fetch_pc already holds the target.
- At most one request outstanding at any time.
- Redirect:
  - Flushes the FIFO that cycle; instr_valid=0 on the next cycle.
  - fetch_pc = redirect_pc & ~3.
  - In WAIT: set drop=1 so the stale response is discarded.
  - In ISSUE: a request issued in the same cycle is suppressed (imem_req forced 0); the target is issued the next cycle.
- Simultaneous redirect and imem_valid in WAIT: the response is discarded, drop stays 0, fetch_pc=target, next state ISSUE.
- Simultaneous redirect and decode handshake: the handshake completes (decode owns that word), then the flush applies.
- Simultaneous push and pop on a full FIFO: allowed; occupancy is unchanged.
- Latency:
  - ISSUE→first instr_valid is 2 cycles with 1-cycle memory.
  - The FIFO is not bypassed, so a pushed word is visible the cycle after imem_valid.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits, wrap-around by natural overflow. Full when MSBs differ and LSBs are equal; empty when the pointers are equal.
- fetch_pc wraps modulo 2^32 with no error.
- Reset mid-WAIT: the state is cleared. A stale imem_valid arriving after reset is ignored because FSM=ISSUE.
- imem_valid outside WAIT is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_stall_cnt[31:0] and perf_redirect_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_stall_cnt increments each cycle instr_valid=0 && instr_ready=1.
  - perf_redirect_cnt increments each cycle redirect=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: the FSM state encoding (FETCH_ISSUE, FETCH_WAIT), the INSTR_W=32 and ADDR_W=32 constants, and the NOP word 32'h0000_0000 (the decode stage treats a zero word as an R-format no-op).
- One sub-module, instr_fifo: a parameterised sync FIFO with push, pop, flush, full, empty and count.

Test Plan:
- Reset then free-running 1-cycle memory, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8,…; instr_pc matches the address; instr equals the memory word; first instr_valid 2 cycles after reset deasserts.
- instr_ready=0 for 10 cycles, FIFO_DEPTH=2 -> exactly 2 words buffered, then imem_req held 0; on release the words pop in order 0x0, 0x4 with no loss or duplicate.
- Redirect to 0x0000_0103 while in WAIT with a 3-cycle memory -> the stale word (PC 0x8) is never presented; next imem_addr=0x0000_0100; next instr_pc=0x100.
- Redirect coincident with imem_valid -> word discarded; imem_req to the target on the following cycle; FIFO empty for one cycle.
- Reset asserted in WAIT, then imem_valid pulses one cycle after reset drops -> ignored; imem_addr=RESET_PC; instr_valid stays 0 until the new response arrives.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000; with FETCH_PERF_CNT_EN, 5 redirects give perf_redirect_cnt=5.
